sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller read/write glue (req/addr/data, done pulse) between NUM_REQ masters: LCD refresh reader, histogram drawer, photon-counter logger. Per-requester handshake is identical to the controller's own: hold req with address/data until a done pulse, then drop req. Grants are round-robin. An optional lock holds the grant across multi-access sequences such as a column clear. The block sits between the masters and the SDRAM controller; the masters never drive the controller directly.

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_rr_pick.sv | 42 ++++
 rtl/sdram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: state encoding, default widths,
// frame-buffer base addresses and the index-width helper.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W    = 24;
  localparam int ARB_DATA_W    = 16;
  localparam int LCD_GRAM_BASE = 0;
  localparam int PHOTON_BASE   = 384000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    HOLD    = 2'd3
  } arb_state_e;

  // A single requester still needs a one-bit index.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first pending bit searching upward from
// (last_i + 1) with wrap, returned as one-hot and as an index.
module sdram_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  assign valid_o = |pending_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && pending_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM read/write controller between NUM_REQ masters.
// Define SDRAM_ARB_LOCK_EN to honour iReq_Lock (grant held across multi-access sequences).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        iReq_Rd,
  input  logic [NUM_REQ-1:0]        iReq_Wr,
  input  logic [NUM_REQ*ADDR_W-1:0] iReq_Addr,
  input  logic [NUM_REQ*DATA_W-1:0] iReq_Wr_Data,
  input  logic [NUM_REQ-1:0]        iReq_Lock,
  output logic [NUM_REQ-1:0]        oRd_Done,
  output logic [NUM_REQ-1:0]        oWr_Done,
  output logic [DATA_W-1:0]         oRd_Data,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic                      oSDRAM_Rd_Req,
  output logic [ADDR_W-1:0]         oSDRAM_Rd_Addr,
  input  logic [DATA_W-1:0]         iSDRAM_Data,
  input  logic                      iSDRAM_Rd_Done,
  output logic                      oSDRAM_Wr_Req,
  output logic [ADDR_W-1:0]         oSDRAM_Wr_Addr,
  output logic [DATA_W-1:0]         oSDRAM_Wr_Data,
  input  logic                      iSDRAM_Wr_Done
);

  localparam int               IDX_W      = arb_idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rdDone_q, rdDone_d;
  logic [NUM_REQ-1:0] wrDone_q, wrDone_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdData_q, rdData_d;
  logic               isWr_q, isWr_d;

  logic [NUM_REQ-1:0] pending, pickGrant;
  logic [IDX_W-1:0]   pickIdx, selIdx;
  logic               pickValid, servedReq;
  logic [ADDR_W-1:0]  capAddr;
  logic [DATA_W-1:0]  capData;
  logic               capWr;

  assign pending = iReq_Rd | iReq_Wr;

  sdram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending_i (pending),
    .last_i    (last_q),
    .grant_o   (pickGrant),
    .idx_o     (pickIdx),
    .valid_o   (pickValid)
  );

  // In IDLE the new winner is captured; in HOLD the current owner re-issues.
  // A write always wins over a simultaneous read from the same requester.
  assign selIdx    = (state_q == IDLE) ? pickIdx : last_q;
  assign capAddr   = iReq_Addr[selIdx*ADDR_W +: ADDR_W];
  assign capData   = iReq_Wr_Data[selIdx*DATA_W +: DATA_W];
  assign capWr     = iReq_Wr[selIdx];
  assign servedReq = isWr_q ? iReq_Wr[last_q] : iReq_Rd[last_q];

`ifndef SDRAM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^iReq_Lock;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    isWr_d   = isWr_q;
    rdData_d = rdData_q;
    rdDone_d = '0;
    wrDone_d = '0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pickGrant;
          last_d  = pickIdx;
          addr_d  = capAddr;
          wdata_d = capData;
          isWr_d  = capWr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (isWr_q && iSDRAM_Wr_Done) begin
          wrDone_d = grant_q;
          state_d  = RELEASE;
        end else if (!isWr_q && iSDRAM_Rd_Done) begin
          rdDone_d = grant_q;
          rdData_d = iSDRAM_Data;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!servedReq) begin
`ifdef SDRAM_ARB_LOCK_EN
          if (iReq_Lock[last_q]) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`else
          state_d = IDLE;
          grant_d = '0;
`endif
        end
      end
`ifdef SDRAM_ARB_LOCK_EN
      HOLD: begin
        if (pending[last_q]) begin
          addr_d  = capAddr;
          wdata_d = capData;
          isWr_d  = capWr;
          state_d = ISSUE;
        end else if (!iReq_Lock[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= LAST_RESET;
      addr_q   <= '0;
      wdata_q  <= '0;
      isWr_q   <= 1'b0;
      rdData_q <= '0;
      rdDone_q <= '0;
      wrDone_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      isWr_q   <= isWr_d;
      rdData_q <= rdData_d;
      rdDone_q <= rdDone_d;
      wrDone_q <= wrDone_d;
    end
  end

  assign oGrant         = grant_q;
  assign oRd_Done       = rdDone_q;
  assign oWr_Done       = wrDone_q;
  assign oRd_Data       = rdData_q;
  assign oSDRAM_Wr_Req  = (state_q == ISSUE) && isWr_q;
  assign oSDRAM_Rd_Req  = (state_q == ISSUE) && !isWr_q;
  assign oSDRAM_Wr_Addr = addr_q;
  assign oSDRAM_Rd_Addr = addr_q;
  assign oSDRAM_Wr_Data = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a behavioural SDRAM controller and
// masters that drop their request on done. Expected order depends on SDRAM_ARB_LOCK_EN.
module tb_sdram_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int MAXW    = 300;
`ifdef SDRAM_ARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  typedef struct {
    bit                isWr;
    int                idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        iReq_Rd = '0;
  logic [NUM_REQ-1:0]        iReq_Wr = '0;
  logic [NUM_REQ*ADDR_W-1:0] iReq_Addr = '0;
  logic [NUM_REQ*DATA_W-1:0] iReq_Wr_Data = '0;
  logic [NUM_REQ-1:0]        iReq_Lock = '0;
  logic [NUM_REQ-1:0]        oRd_Done, oWr_Done, oGrant;
  logic [DATA_W-1:0]         oRd_Data;
  logic                      oSDRAM_Rd_Req, oSDRAM_Wr_Req;
  logic [ADDR_W-1:0]         oSDRAM_Rd_Addr, oSDRAM_Wr_Addr;
  logic [DATA_W-1:0]         oSDRAM_Wr_Data;
  logic [DATA_W-1:0]         iSDRAM_Data = '0;
  logic                      iSDRAM_Rd_Done = 1'b0;
  logic                      iSDRAM_Wr_Done = 1'b0;

  exp_t doneQ[$];
  exp_t ctlQ[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  int                checks = 0;
  int                errors = 0;
  int                ctlLat = 2;
  int                ctlCnt = 0;
  bit                ctlBusy = 1'b0;
  bit                ctlIsWr = 1'b0;
  logic [ADDR_W-1:0] ctlAddr = '0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .iReq_Rd        (iReq_Rd),
    .iReq_Wr        (iReq_Wr),
    .iReq_Addr      (iReq_Addr),
    .iReq_Wr_Data   (iReq_Wr_Data),
    .iReq_Lock      (iReq_Lock),
    .oRd_Done       (oRd_Done),
    .oWr_Done       (oWr_Done),
    .oRd_Data       (oRd_Data),
    .oGrant         (oGrant),
    .oSDRAM_Rd_Req  (oSDRAM_Rd_Req),
    .oSDRAM_Rd_Addr (oSDRAM_Rd_Addr),
    .iSDRAM_Data    (iSDRAM_Data),
    .iSDRAM_Rd_Done (iSDRAM_Rd_Done),
    .oSDRAM_Wr_Req  (oSDRAM_Wr_Req),
    .oSDRAM_Wr_Addr (oSDRAM_Wr_Addr),
    .oSDRAM_Wr_Data (oSDRAM_Wr_Data),
    .iSDRAM_Wr_Done (iSDRAM_Wr_Done)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectAccess(input int k, input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
    exp_t e;
    e.isWr = wr;
    e.idx  = k;
    e.addr = addr;
    e.data = data;
    doneQ.push_back(e);
    ctlQ.push_back(e);
  endtask

  // Raises requester k's Wr and/or Rd; expectations queue in service order
  // (write before read) unless the caller defers them.
  task automatic applyStimulus(input int k, input bit wr, input bit rd,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input logic [DATA_W-1:0] rdExp, input bit defer);
    iReq_Addr[k*ADDR_W +: ADDR_W]    = addr;
    iReq_Wr_Data[k*DATA_W +: DATA_W] = wdata;
    if (wr) begin
      iReq_Wr[k] = 1'b1;
      if (!defer) expectAccess(k, 1'b1, addr, wdata);
    end
    if (rd) begin
      iReq_Rd[k] = 1'b1;
      if (!defer) expectAccess(k, 1'b0, addr, rdExp);
    end
  endtask

  // One cycle of master and controller behaviour, evaluated at the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    iSDRAM_Wr_Done = 1'b0;
    iSDRAM_Rd_Done = 1'b0;
    iSDRAM_Data    = 16'hDEAD;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oWr_Done[k]) iReq_Wr[k] = 1'b0;
      if (oRd_Done[k]) iReq_Rd[k] = 1'b0;
    end
    if (!rst) begin
      if (ctlBusy) begin
        if (!(oSDRAM_Wr_Req || oSDRAM_Rd_Req)) begin
          ctlBusy = 1'b0;
        end else if (ctlCnt > 1) begin
          ctlCnt--;
        end else if (ctlCnt == 1) begin
          ctlCnt = 0;
          if (ctlIsWr) begin
            iSDRAM_Wr_Done = 1'b1;
          end else begin
            iSDRAM_Rd_Done = 1'b1;
            iSDRAM_Data    = mem.exists(ctlAddr) ? mem[ctlAddr] : '0;
          end
        end
      end else if (oSDRAM_Wr_Req || oSDRAM_Rd_Req) begin
        ctlBusy = 1'b1;
        ctlCnt  = ctlLat;
        ctlIsWr = oSDRAM_Wr_Req;
        ctlAddr = ctlIsWr ? oSDRAM_Wr_Addr : oSDRAM_Rd_Addr;
        if (ctlQ.size() == 0) begin
          checkOutput("ctl_unexpected_access", 64'(ctlQ.size()), 64'd1);
        end else begin
          e = ctlQ.pop_front();
          checkOutput("ctl_op_is_write", 64'(ctlIsWr), 64'(e.isWr));
          checkOutput("ctl_addr", 64'(ctlAddr), 64'(e.addr));
          checkOutput("ctl_both_req", 64'(oSDRAM_Wr_Req && oSDRAM_Rd_Req), 64'd0);
          if (ctlIsWr) begin
            checkOutput("ctl_wr_data", 64'(oSDRAM_Wr_Data), 64'(e.data));
            mem[ctlAddr] = oSDRAM_Wr_Data;
          end
        end
      end
    end
  endtask

  task automatic waitReqLow(input string name, input int k);
    int n = 0;
    while (iReq_Wr[k] && n < MAXW) begin
      tick();
      n++;
    end
    checkOutput({name, "_in_time"}, 64'(n < MAXW), 64'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (((iReq_Rd | iReq_Wr) != '0 || doneQ.size() != 0) && n < MAXW) begin
      tick();
      n++;
    end
    checkOutput({name, "_in_time"}, 64'(n < MAXW), 64'd1);
    repeat (2) tick();
  endtask

  // Monitor: every done pulse pops one expectation and must match it exactly.
  initial begin
    exp_t               e;
    logic [NUM_REQ-1:0] oneHot;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (|oRd_Done || |oWr_Done)) begin
        if (doneQ.size() == 0) begin
          checkOutput("done_unexpected", 64'(doneQ.size()), 64'd1);
        end else begin
          e      = doneQ.pop_front();
          oneHot = NUM_REQ'(1) << e.idx;
          checkOutput("done_wr_vector", 64'(oWr_Done), e.isWr ? 64'(oneHot) : 64'd0);
          checkOutput("done_rd_vector", 64'(oRd_Done), e.isWr ? 64'd0 : 64'(oneHot));
          checkOutput("done_grant", 64'(oGrant), 64'(oneHot));
          if (!e.isWr) checkOutput("rd_data", 64'(oRd_Data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) tick();
    checkOutput("reset_grant", 64'(oGrant), 64'd0);
    checkOutput("reset_wr_req", 64'(oSDRAM_Wr_Req), 64'd0);
    checkOutput("reset_rd_req", 64'(oSDRAM_Rd_Req), 64'd0);
    checkOutput("reset_dones", 64'({oRd_Done, oWr_Done}), 64'd0);
    checkOutput("reset_rd_data", 64'(oRd_Data), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] round robin, all three requesters twice");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        applyStimulus(k, 1'b1, 1'b0, 24'h000100 + 24'(k*16 + r), 16'h1000 + 16'(k + r*8), '0, 1'b0);
      end
      waitIdle("rr_round");
    end

    $display("[TB] single write from requester 1");
    ctlLat = 4;
    applyStimulus(1, 1'b1, 1'b0, 24'd384000, 16'h1234, '0, 1'b0);
    tick();
    checkOutput("single_grant_t1", 64'(oGrant), 64'h2);
    checkOutput("single_wr_req_t1", 64'(oSDRAM_Wr_Req), 64'd1);
    checkOutput("single_rd_req_t1", 64'(oSDRAM_Rd_Req), 64'd0);
    waitReqLow("single_done", 1);
    checkOutput("single_ctl_req_dropped", 64'(oSDRAM_Wr_Req), 64'd0);
    tick();
    checkOutput("single_grant_released", 64'(oGrant), 64'd0);
    waitIdle("single");
    ctlLat = 2;

    $display("[TB] read from requester 2");
    mem[24'h000040] = 16'h00C8;
    applyStimulus(2, 1'b0, 1'b1, 24'h000040, '0, 16'h00C8, 1'b0);
    waitIdle("read");

    $display("[TB] simultaneous write and read from requester 0");
    applyStimulus(0, 1'b1, 1'b1, 24'h000200, 16'hBEEF, 16'hBEEF, 1'b0);
    waitIdle("rdwr");

    $display("[TB] locked burst from requester 1 with requester 0 pending");
    iReq_Lock[1] = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 24'd384016, 16'hA000, '0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 24'h000300, 16'h5555, '0, LOCK_BUILD);
    for (int w = 1; w < 4; w++) begin
      waitReqLow("lock_step", 1);
      tick();
      applyStimulus(1, 1'b1, 1'b0, 24'd384016 + 24'(w), 16'hA000 + 16'(w), '0, 1'b0);
    end
    waitReqLow("lock_last", 1);
    iReq_Lock[1] = 1'b0;
    if (LOCK_BUILD) expectAccess(0, 1'b1, 24'h000300, 16'h5555);
    waitIdle("lock");

    $display("[TB] reset during an access");
    ctlLat = 6;
    applyStimulus(1, 1'b1, 1'b0, 24'h000400, 16'h7777, '0, 1'b0);
    n = 0;
    while (!oSDRAM_Wr_Req && n < MAXW) begin
      tick();
      n++;
    end
    checkOutput("mid_issue_reached", 64'(oSDRAM_Wr_Req), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_grant", 64'(oGrant), 64'd0);
    checkOutput("rst_wr_req", 64'(oSDRAM_Wr_Req), 64'd0);
    checkOutput("rst_wr_addr", 64'(oSDRAM_Wr_Addr), 64'd0);
    checkOutput("rst_wr_data", 64'(oSDRAM_Wr_Data), 64'd0);
    checkOutput("rst_rd_data", 64'(oRd_Data), 64'd0);
    checkOutput("rst_dones", 64'({oRd_Done, oWr_Done}), 64'd0);
    iReq_Wr = '0;
    iReq_Rd = '0;
    ctlBusy = 1'b0;
    doneQ.delete();
    ctlQ.delete();
    repeat (2) tick();
    rst    = 1'b0;
    ctlLat = 2;
    tick();
    applyStimulus(0, 1'b1, 1'b0, 24'h000500, 16'h0A0A, '0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 24'h000600, 16'h0B0B, '0, 1'b0);
    tick();
    checkOutput("post_reset_first_grant", 64'(oGrant), 64'h1);
    waitIdle("post_reset");

    checkOutput("done_queue_drained", 64'(doneQ.size()), 64'd0);
    checkOutput("ctl_queue_drained", 64'(ctlQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
